decode_stage_hs: RTL and testbench

//  Parametrised decode stage with valid/ready handshakes on both sides. Sits between fetch (IF/ID) and

---
 rtl/decode_stage_hs.sv | 194 +++++++++++++++++++
 tb/tb_decode_stage_hs.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_hs.sv
`timescale 1ns/1ps
// Decode stage between fetch and execute with valid/ready on both sides.
// Splits the instruction, reads/forwards operands, places immediates and
// stalls load-use / load-WAW hazards using a pending-load scoreboard.
module decode_stage_hs #(
  parameter int DATA_W       = 32,
  parameter int NREGS        = 8,
  parameter int SIGN_EXT_IMM = 0,
  parameter int FWD_EN       = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic [2:0]        rs1_addr,
  output logic [2:0]        rs2_addr,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  input  logic              wb_valid,
  input  logic [2:0]        wb_reg,
  input  logic [1:0]        wb_en,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ld_done_valid,
  input  logic [2:0]        ld_done_reg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        alu_opcode,
  output logic [4:0]        mem_code,
  output logic [2:0]        audio_opcode,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic [1:0]        wb_en_out,
  output logic [2:0]        wb_reg_out,
  output logic [2:0]        wb_sel,
  output logic [1:0]        audio_ch,
  output logic [31:0]       out_instr
);

  typedef enum logic [1:0] {T_NOP = 2'b00, T_ALU = 2'b01, T_MEM = 2'b10, T_AUDIO = 2'b11} itype_e;

  // Register fields outside the implemented file alias to r0.
  function automatic logic [2:0] reg_idx(input logic [2:0] f);
    return (int'(f) < NREGS) ? f : 3'd0;
  endfunction

  itype_e      itype;
  logic [2:0]  op;
  logic        imm_f;
  logic [15:0] imm16;
  logic        is_move, mv_lo, mv_hi, is_load, ent_load;
  logic        reads1, reads2, hazard, fire;
  logic [7:0]  sb, sb_next, busy;
  logic [DATA_W-1:0] v1, v2, ext16, hi16, mid16;

  logic [2:0]        d_alu, d_aud, d_wsel;
  logic [4:0]        d_mem;
  logic [1:0]        d_wen;
  logic [DATA_W-1:0] d_op1, d_op2;

  assign itype    = itype_e'(in_instr[30:29]);
  assign op       = in_instr[28:26];
  assign imm_f    = in_instr[31];
  assign imm16    = in_instr[15:0];
  assign rs1_addr = in_instr[21:19];
  assign rs2_addr = in_instr[18:16];

  assign is_move  = (itype == T_ALU) && (op inside {3'b101, 3'b110, 3'b111});
  assign mv_lo    = (itype == T_ALU) && (op == 3'b101);
  assign mv_hi    = (itype == T_ALU) && (op == 3'b110);
  assign is_load  = (itype == T_MEM) && (op inside {3'b001, 3'b010});
  assign ent_load = (out_instr[30:29] == T_MEM) &&
                    (out_instr[28:26] inside {3'b001, 3'b010});

  assign reads1 = (itype != T_NOP) && !(imm_f && (mv_lo || mv_hi));
  assign reads2 = (itype != T_NOP) && !imm_f;

  assign ext16 = (SIGN_EXT_IMM != 0) ? DATA_W'($signed(imm16)) : DATA_W'(imm16);
  assign hi16  = DATA_W'(imm16) << (DATA_W - 16);
  assign mid16 = DATA_W'({imm16, 8'h00});

  // Registers pending a load, including a load still sitting in the ID/EX entry.
  always_comb begin
    busy = sb;
    if (out_valid && ent_load) busy[reg_idx(wb_reg_out)] = 1'b1;
  end

  assign hazard   = (reads1 && busy[reg_idx(rs1_addr)]) ||
                    (reads2 && busy[reg_idx(rs2_addr)]) ||
                    (is_load && busy[reg_idx(rs1_addr)]);
  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign fire     = in_valid && in_ready;

  // Operand read with writeback bypass on a per-half basis.
  always_comb begin
    v1 = rf_rdata1;
    v2 = rf_rdata2;
    if (FWD_EN != 0 && wb_valid) begin
      if (wb_reg == rs1_addr) begin
        if (wb_en[1]) v1[DATA_W-1:16] = wb_data[DATA_W-1:16];
        if (wb_en[0]) v1[15:0]        = wb_data[15:0];
      end
      if (wb_reg == rs2_addr) begin
        if (wb_en[1]) v2[DATA_W-1:16] = wb_data[DATA_W-1:16];
        if (wb_en[0]) v2[15:0]        = wb_data[15:0];
      end
    end
  end

  // Field decode and immediate placement for the next ID/EX entry.
  always_comb begin
    d_alu  = '0;
    d_aud  = '0;
    d_mem  = '0;
    d_wsel = '0;
    d_wen  = '0;
    d_op1  = '0;
    d_op2  = '0;
    if (itype != T_NOP) begin
      d_op1 = v1;
      d_op2 = v2;
      unique case (itype)
        T_ALU:   begin
          d_wsel = is_move ? 3'b001 : 3'b100;
          d_alu  = is_move ? 3'b000 : op;
          d_wen  = mv_lo ? 2'b01 : (mv_hi ? 2'b10 : 2'b11);
        end
        T_MEM:   begin
          d_wsel = 3'b010;
          d_mem  = {op[2], op[1], op[1], op[0], op[0]};
          if (is_load) d_wen = (op == 3'b001) ? 2'b01 : 2'b10;
        end
        T_AUDIO: d_aud = op;
        default: ;
      endcase
      if (imm_f) begin
        if ((itype == T_ALU && !is_move) || itype == T_MEM || mv_lo) d_op2 = ext16;
        else if (mv_hi)                                           d_op2 = hi16;
        else if (itype == T_AUDIO && op == 3'b100)                d_op1 = hi16;
        else if (itype == T_AUDIO && op == 3'b110)                d_op1 = mid16;
      end
    end
  end

  // Pending-load scoreboard: clear on load completion, set when a load leaves; set wins.
  always_comb begin
    sb_next = sb;
    if (ld_done_valid) sb_next[reg_idx(ld_done_reg)] = 1'b0;
    if (out_valid && out_ready && ent_load && !flush) sb_next[reg_idx(wb_reg_out)] = 1'b1;
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sb <= '0;
    else         sb <= sb_next;
  end

  // ID/EX entry: flush beats capture, capture beats drain, otherwise hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid    <= 1'b0;
      alu_opcode   <= '0;
      mem_code     <= '0;
      audio_opcode <= '0;
      op1          <= '0;
      op2          <= '0;
      wb_en_out    <= '0;
      wb_reg_out   <= '0;
      wb_sel       <= '0;
      audio_ch     <= '0;
      out_instr    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_instr <= '0;
    end else if (fire) begin
      out_valid    <= 1'b1;
      alu_opcode   <= d_alu;
      mem_code     <= d_mem;
      audio_opcode <= d_aud;
      op1          <= d_op1;
      op2          <= d_op2;
      wb_en_out    <= d_wen;
      wb_reg_out   <= (itype == T_NOP) ? 3'd0 : rs1_addr;
      wb_sel       <= d_wsel;
      audio_ch     <= (itype == T_NOP) ? 2'd0 : in_instr[25:24];
      out_instr    <= in_instr;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_instr <= '0;
    end
  end

endmodule

// File: tb/tb_decode_stage_hs.sv
`timescale 1ns/1ps
// Scoreboard bench for decode_stage_hs: directed scenarios followed by random traffic.
module tb_decode_stage_hs;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam int SX = 1;
  localparam int FW = 1;

  logic clk, resetn, flush, in_valid, in_ready;
  logic [31:0] in_instr;
  logic [2:0] rs1_addr, rs2_addr;
  logic [DW-1:0] rf_rdata1, rf_rdata2;
  logic wb_valid;
  logic [2:0] wb_reg;
  logic [1:0] wb_en;
  logic [DW-1:0] wb_data;
  logic ld_done_valid;
  logic [2:0] ld_done_reg;
  logic out_valid, out_ready;
  logic [2:0] alu_opcode, audio_opcode, wb_reg_out, wb_sel;
  logic [4:0] mem_code;
  logic [DW-1:0] op1, op2;
  logic [1:0] wb_en_out, audio_ch;
  logic [31:0] out_instr;

  decode_stage_hs #(.DATA_W(DW), .NREGS(NR), .SIGN_EXT_IMM(SX), .FWD_EN(FW)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_valid(wb_valid), .wb_reg(wb_reg),
    .wb_en(wb_en), .wb_data(wb_data), .ld_done_valid(ld_done_valid), .ld_done_reg(ld_done_reg),
    .out_valid(out_valid), .out_ready(out_ready), .alu_opcode(alu_opcode), .mem_code(mem_code),
    .audio_opcode(audio_opcode), .op1(op1), .op2(op2), .wb_en_out(wb_en_out),
    .wb_reg_out(wb_reg_out), .wb_sel(wb_sel), .audio_ch(audio_ch), .out_instr(out_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  alu;
    logic [4:0]  mem;
    logic [2:0]  aud;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  wen;
    logic [2:0]  wreg;
    logic [2:0]  wsel;
    logic [1:0]  ch;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;

  // Reference state of the decode stage as seen from outside.
  logic [7:0] m_sb;
  logic       m_valid, m_load;
  logic [2:0] m_dest;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input bit imm, input logic [1:0] t, input logic [2:0] op,
                                     input logic [2:0] rd, input logic [2:0] rs2,
                                     input logic [15:0] i16, input logic [1:0] ch);
    return {imm, t, op, ch, 2'b00, rd, rs2, i16};
  endfunction

  function automatic logic [2:0] eidx(input logic [2:0] f);
    return (int'(f) < NR) ? f : 3'd0;
  endfunction

  function automatic logic [31:0] fwd(input logic [31:0] v, input logic [2:0] r);
    logic [31:0] mask;
    if (FW == 0 || !wb_valid || wb_reg != r) return v;
    mask = {{16{wb_en[1]}}, {16{wb_en[0]}}};
    return (v & ~mask) | (wb_data & mask);
  endfunction

  function automatic exp_t predict(input logic [31:0] ins, input logic [31:0] v1, input logic [31:0] v2);
    exp_t e;
    logic [1:0] t;
    logic [2:0] op;
    logic [15:0] i16;
    logic load;
    t = ins[30:29]; op = ins[28:26]; i16 = ins[15:0];
    e.alu = 0; e.mem = 0; e.aud = 0; e.op1 = 0; e.op2 = 0;
    e.wen = 0; e.wreg = 0; e.wsel = 0; e.ch = 0; e.instr = ins;
    if (t == 2'd0) return e;
    e.wreg = ins[21:19];
    e.ch   = ins[25:24];
    load   = (t == 2'd2) && (op == 3'd1 || op == 3'd2);
    if (t == 2'd1 && op >= 3'd5) e.wsel = 3'b001;
    else if (t == 2'd1) begin e.wsel = 3'b100; e.alu = op; end
    else if (t == 2'd2) begin e.wsel = 3'b010; e.mem = {op[2], op[1], op[1], op[0], op[0]}; end
    else e.aud = op;
    if ((t == 2'd1 && op == 3'd5) || (load && op == 3'd1)) e.wen = 2'b01;
    else if ((t == 2'd1 && op == 3'd6) || (load && op == 3'd2)) e.wen = 2'b10;
    else if (t == 2'd1) e.wen = 2'b11;
    e.op1 = v1;
    e.op2 = v2;
    if (ins[31]) begin
      if ((t == 2'd1 && op <= 3'd5) || t == 2'd2)
        e.op2 = (SX != 0) ? 32'($signed(i16)) : 32'(i16);
      else if (t == 2'd1 && op == 3'd6) e.op2 = {i16, 16'h0000};
      else if (t == 2'd3 && op == 3'd4) e.op1 = {i16, 16'h0000};
      else if (t == 2'd3 && op == 3'd6) e.op1 = 32'(i16) * 256;
    end
    return e;
  endfunction

  task automatic idle();
    in_valid = 0; in_instr = 0; flush = 0; out_ready = 1;
    wb_valid = 0; wb_reg = 0; wb_en = 0; wb_data = 0;
    ld_done_valid = 0; ld_done_reg = 0;
    rf_rdata1 = $urandom; rf_rdata2 = $urandom;
  endtask

  task automatic model_reset();
    m_sb = 0; m_valid = 0; m_load = 0; m_dest = 0;
    exp_q.delete();
  endtask

  // One clock: inputs already set at posedge+1; predict, check in_ready, advance model.
  task automatic step();
    logic [7:0] busy, nsb;
    logic [1:0] t;
    logic [2:0] op;
    logic r1, r2, ld, hz, rdy, fire, pf, nvalid, nload;
    logic [2:0] ndest;
    exp_t rec;
    #1;
    t = in_instr[30:29]; op = in_instr[28:26];
    busy = m_sb;
    if (m_valid && m_load) busy[eidx(m_dest)] = 1'b1;
    r1 = (t != 0) && !(in_instr[31] && t == 2'd1 && (op == 3'd5 || op == 3'd6));
    r2 = (t != 0) && !in_instr[31];
    ld = (t == 2'd2) && (op == 3'd1 || op == 3'd2);
    hz = (r1 && busy[eidx(in_instr[21:19])]) || (r2 && busy[eidx(in_instr[18:16])]) ||
         (ld && busy[eidx(in_instr[21:19])]);
    rdy = (!m_valid || out_ready) && !hz && !flush;
    check("in_ready", in_ready, rdy);
    fire = in_valid && rdy;
    rec = predict(in_instr, fwd(rf_rdata1, in_instr[21:19]), fwd(rf_rdata2, in_instr[18:16]));
    nsb = m_sb;
    if (ld_done_valid) nsb[eidx(ld_done_reg)] = 1'b0;
    if (m_valid && out_ready && m_load && !flush) nsb[eidx(m_dest)] = 1'b1;
    nvalid = m_valid; nload = m_load; ndest = m_dest;
    if (flush) nvalid = 0;
    else if (fire) begin nvalid = 1; nload = ld; ndest = (t == 0) ? 3'd0 : in_instr[21:19]; end
    else if (out_ready) nvalid = 0;
    pf = flush;
    @(posedge clk);
    m_sb = nsb; m_valid = nvalid; m_load = nload; m_dest = ndest;
    if (pf) exp_q.delete();
    if (fire) exp_q.push_back(rec);
    #1;
  endtask

  // Monitor: compare the presented entry against the queue head; retire on handshake.
  always @(negedge clk) begin
    if (resetn) begin
      check("out_valid", out_valid, exp_q.size() != 0);
      if (!out_valid) check("out_instr_idle", out_instr, 0);
      else if (exp_q.size() != 0) begin
        check("alu_opcode", alu_opcode, exp_q[0].alu);
        check("mem_code", mem_code, exp_q[0].mem);
        check("audio_opcode", audio_opcode, exp_q[0].aud);
        check("op1", op1, exp_q[0].op1);
        check("op2", op2, exp_q[0].op2);
        check("wb_en_out", wb_en_out, exp_q[0].wen);
        check("wb_reg_out", wb_reg_out, exp_q[0].wreg);
        check("wb_sel", wb_sel, exp_q[0].wsel);
        check("audio_ch", audio_ch, exp_q[0].ch);
        check("out_instr", out_instr, exp_q[0].instr);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    resetn = 0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_op1", op1, 0);
    check("rst_op2", op2, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_wb_sel", wb_sel, 0);
    check("rst_in_ready", in_ready, 1);
    resetn = 1;

    // Back-to-back ADD rs1=2, rs2=3.
    for (int i = 0; i < 4; i++) begin
      idle(); in_valid = 1; in_instr = mk(0, 2'd1, 3'd0, 3'd2, 3'd3, 16'(i), 2'd0);
      step();
    end

    // Load r4, then an ADD reading r4 stalls until the load completes.
    idle(); in_valid = 1; in_instr = mk(0, 2'd2, 3'd1, 3'd4, 3'd0, 16'h0010, 2'd0); step();
    for (int i = 0; i < 5; i++) begin
      idle(); in_valid = 1; in_instr = mk(0, 2'd1, 3'd0, 3'd5, 3'd4, 16'h0, 2'd0);
      if (i == 3) begin ld_done_valid = 1; ld_done_reg = 3'd4; end
      step();
    end
    check("load_use_released", out_instr, mk(0, 2'd1, 3'd0, 3'd5, 3'd4, 16'h0, 2'd0));

    // Move-high places imm16 at the top; held while out_ready=0.
    idle(); in_valid = 1; in_instr = mk(1, 2'd1, 3'd6, 3'd2, 3'd0, 16'hABCD, 2'd0); step();
    check("movh_op2", op2, 32'hABCD0000);
    check("movh_wen", wb_en_out, 2'b10);
    for (int i = 0; i < 3; i++) begin
      idle(); out_ready = 0; in_valid = 1; in_instr = mk(0, 2'd1, 3'd1, 3'd1, 3'd1, 16'h0, 2'd0);
      step();
    end
    idle(); step();

    // Move-low with sign extension.
    idle(); in_valid = 1; in_instr = mk(1, 2'd1, 3'd5, 3'd2, 3'd0, 16'h8001, 2'd0); step();
    check("movl_op2", op2, 32'hFFFF8001);

    // Lower-half forwarding into rs2.
    idle(); in_valid = 1; in_instr = mk(0, 2'd1, 3'd0, 3'd1, 3'd3, 16'h0, 2'd0);
    rf_rdata2 = 32'hAAAABBBB; wb_valid = 1; wb_reg = 3'd3; wb_en = 2'b01; wb_data = 32'h12345678;
    step();
    check("fwd_op2", op2, 32'hAAAA5678);

    // Flush a held load: entry dropped and r6 never becomes busy.
    idle(); in_valid = 1; in_instr = mk(0, 2'd2, 3'd2, 3'd6, 3'd0, 16'h0, 2'd0); step();
    idle(); out_ready = 0; step();
    idle(); out_ready = 1; flush = 1; step();
    check("flush_out_valid", out_valid, 0);
    idle(); in_valid = 1; in_instr = mk(0, 2'd1, 3'd0, 3'd1, 3'd6, 16'h0, 2'd0); step();

    // Async reset while a stalled entry is held.
    idle(); in_valid = 1; in_instr = mk(0, 2'd2, 3'd1, 3'd7, 3'd0, 16'h0, 2'd1); step();
    idle(); out_ready = 0; step();
    resetn = 0;
    model_reset();
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_instr", out_instr, 0);
    @(posedge clk); #1;
    resetn = 1;
    idle(); in_valid = 1; in_instr = mk(0, 2'd1, 3'd0, 3'd1, 3'd7, 16'h0, 2'd0); step();

    // Random traffic with small register range so hazards occur often.
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] t;
      idle();
      t = 2'($urandom_range(0, 3));
      in_valid = ($urandom_range(0, 3) != 0);
      in_instr = (t == 0) ? 32'h0 :
                 mk(1'($urandom), t, 3'($urandom), 3'($urandom_range(0, 3)),
                    3'($urandom_range(0, 3)), 16'($urandom), 2'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      wb_valid = 1'($urandom); wb_reg = 3'($urandom_range(0, 3));
      wb_en = 2'($urandom); wb_data = $urandom;
      ld_done_valid = ($urandom_range(0, 2) == 0); ld_done_reg = 3'($urandom_range(0, 3));
      step();
    end
    idle(); step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
